// File: rtl/ldst_pkg.sv
// Shared types and constants for the load/store stage.
// Imported by ldst_unit.
package ldst_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WB_DATA = 3'd2,
    WB_PTR  = 3'd3
  } ldst_state_t;

  localparam int RM_IDX = 15;

endpackage

// File: rtl/ldst_unit.sv
// Multi-cycle load/store stage: req/ack data memory port,
// register write-back of load data and optional rM post-increment.
module ldst_unit
  import ldst_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int REG_AW  = 4,
  parameter int RM_IDX  = ldst_pkg::RM_IDX,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic              post_inc,
  input  logic [REG_AW-1:0] rd,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] sdata_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [REG_AW-1:0] RM_A = REG_AW'(RM_IDX);

  ldst_state_t       state;
  logic              store_q;
  logic              pinc_q;
  logic [REG_AW-1:0] rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] ptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      store_q <= 1'b0;
      pinc_q  <= 1'b0;
      rd_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            store_q <= is_store;
            pinc_q  <= post_inc;
            rd_q    <= rd;
            addr_q  <= addr_in;
            sdata_q <= sdata_in;
            cnt     <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          // ack wins even on the last allowed cycle
          if (mem_ack) begin
            if (!store_q) begin
              rdata_q <= mem_rdata;
              state   <= WB_DATA;
            end else if (pinc_q) begin
              state <= WB_PTR;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else if (cnt == TMO_LAST) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WB_DATA: begin
          if (pinc_q) begin
            state <= WB_PTR;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        WB_PTR: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ptr_nxt   = addr_q + A_ONE;
  assign busy      = (state != IDLE);
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & store_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = sdata_q;

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    unique case (1'b1)
      (state == WB_DATA): begin
        wb_en   = 1'b1;
        wb_addr = rd_q;
        wb_data = rdata_q;
      end
      (state == WB_PTR): begin
        wb_en   = 1'b1;
        wb_addr = RM_A;
        wb_data = DATA_W'(ptr_nxt);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldst_unit.sv
// Directed bench for ldst_unit: loads, stores, post-increment,
// timeout abort, held start and reset during write-back.
module tb_ldst_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       is_store;
  logic       post_inc;
  logic [3:0] rd;
  logic [7:0] addr_in;
  logic [7:0] sdata_in;
  logic       busy;
  logic       done;
  logic       err;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       wb_en;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;

  int n_chk = 0;
  int n_fail = 0;

  logic [11:0] wb_log[$];
  logic [7:0]  rf[16];

  ldst_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .is_store(is_store), .post_inc(post_inc), .rd(rd),
    .addr_in(addr_in), .sdata_in(sdata_in),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // register file model on the write port
  always @(posedge clk) begin
    if (wb_en) begin
      wb_log.push_back({wb_addr, wb_data});
      rf[wb_addr] <= wb_data;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic go(input logic st, input logic pi,
                    input logic [3:0] r, input logic [7:0] a,
                    input logic [7:0] sd);
    start = 1'b1; is_store = st; post_inc = pi;
    rd = r; addr_in = a; sdata_in = sd;
  endtask

  int base;
  int nreq;
  int ndone;
  int nerr;
  int nwb;

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0;
    post_inc = 1'b0; rd = '0; addr_in = '0;
    sdata_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_ctl", {busy, done, err, mem_req, mem_we, wb_en}, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);
    check("rst_wb", {wb_addr, wb_data}, 0);
    reset = 1'b0;
    step();

    // 1: zero-wait load
    base = wb_log.size();
    go(1'b0, 1'b0, 4'd3, 8'h10, 8'h00);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    step(); start = 1'b0;
    check("t1_c1_req", {busy, mem_req, mem_we, wb_en}, 4'b1100);
    check("t1_c1_addr", mem_addr, 8'h10);
    step(); mem_ack = 1'b0;
    check("t1_c2_wb", {wb_en, wb_addr, wb_data}, {1'b1, 4'd3, 8'hA5});
    check("t1_c2_done", {done, mem_req}, 0);
    step();
    check("t1_c3_done", {done, busy, wb_en}, 3'b100);
    step();
    check("t1_c4_quiet", {done, err}, 0);
    check("t1_nwb", wb_log.size() - base, 1);

    // 2: store + post_inc, ack on third REQ cycle
    base = wb_log.size();
    go(1'b1, 1'b1, 4'd0, 8'hFF, 8'h3C);
    step(); start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check("t2_req", {mem_req, mem_we, wb_en}, 3'b110);
      check("t2_addr", {mem_addr, mem_wdata}, {8'hFF, 8'h3C});
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    check("t2_ptr", {wb_en, wb_addr, wb_data}, {1'b1, 4'd15, 8'h00});
    check("t2_ptr_req", {mem_req, done}, 0);
    step();
    check("t2_done", {done, busy}, 2'b10);
    check("t2_nwb", wb_log.size() - base, 1);

    // 3: timeout
    base = wb_log.size();
    nreq = 0;
    nwb = 0;
    go(1'b0, 1'b0, 4'd5, 8'h40, 8'h00);
    step(); start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (mem_req) nreq++;
      if (wb_en) nwb++;
      step();
    end
    check("t3_busy_end", busy, 1'b0);
    check("t3_req_cycles", nreq, 15);
    check("t3_err", {err, done}, 2'b10);
    step();
    check("t3_err_once", err, 1'b0);
    check("t3_nwb", (wb_log.size() - base) + nwb, 0);

    // 4: start held high, load + post_inc, 0-wait
    go(1'b0, 1'b1, 4'd2, 8'h08, 8'h00);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    nreq = 0; ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (mem_req) nreq++;
      if (done) ndone++;
      if (i == 4) check("t4_c4_idle", {done, busy}, 2'b10);
      if (i == 5) check("t4_c5_req", mem_req, 1'b1);
    end
    start = 1'b0; mem_ack = 1'b0;
    check("t4_nreq", nreq, 2);
    check("t4_ndone", ndone, 2);
    step(); step();

    // 5: reset in WB_DATA
    base = wb_log.size();
    go(1'b0, 1'b1, 4'd6, 8'h30, 8'h00);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    step(); start = 1'b0;
    step(); mem_ack = 1'b0;
    check("t5_wbdata", {wb_en, wb_addr, wb_data}, {1'b1, 4'd6, 8'h5A});
    reset = 1'b1;
    step();
    check("t5_rst_ctl", {busy, done, err, mem_req, mem_we, wb_en}, 0);
    check("t5_rst_dat", {mem_addr, mem_wdata, wb_addr, wb_data}, 0);
    reset = 1'b0;
    nerr = 0; ndone = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || err) ndone++;
      if (wb_en || busy) nerr++;
    end
    check("t5_no_done", ndone, 0);
    check("t5_no_act", nerr, 0);
    check("t5_nwb", wb_log.size() - base, 1);

    // 6: load into rM with post_inc
    base = wb_log.size();
    go(1'b0, 1'b1, 4'd15, 8'h20, 8'h00);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    step(); start = 1'b0;
    step(); mem_ack = 1'b0;
    step(); step();
    check("t6_done", {done, busy}, 2'b10);
    step();
    check("t6_nwb", wb_log.size() - base, 2);
    if (wb_log.size() - base == 2) begin
      check("t6_wb0", wb_log[base], {4'd15, 8'h77});
      check("t6_wb1", wb_log[base+1], {4'd15, 8'h21});
    end
    check("t6_rm", rf[15], 8'h21);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
